ram_copy_engine: RTL and testbench

- Bus initiator for the 8-bit tristate RAM bus (chipSelect / writeEnabled / address / shared data).
- Performs block copy (read byte, write byte) or block fill (write-only) of `length` bytes without CPU involvement.
- Sits between the CPU-side control registers and the RAM port.
- Owns the bus while busy; the arbiter must keep other initiators off the bus during that time.

---
 rtl/ram_bus_pkg.sv | 17 +
 rtl/ram_copy_ptr.sv | 27 ++
 rtl/ram_copy_engine.sv | 127 ++++++++++++
 tb/tb_ram_copy_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus copy/fill engine: FSM states, mode
// encodings and the data bus width.
package ram_bus_pkg;

  localparam int DATA_W = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ram_copy_ptr.sv
// Bits-wide address pointer: loads a base address, then steps up or down
// by one per enabled cycle, wrapping modulo 2^Bits.
module ram_copy_ptr #(
  parameter int Bits = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [Bits-1:0] load_value,
  input  logic            step,
  input  logic            down,
  output logic [Bits-1:0] ptr
);

  localparam logic [Bits-1:0] ONE = {{(Bits-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_value;
    end else if (step) begin
      ptr <= down ? ptr - ONE : ptr + ONE;
    end
  end

endmodule

// File: rtl/ram_copy_engine.sv
// RAM bus initiator that copies or fills a block of bytes on the shared
// tristate RAM bus while holding the bus for the whole transfer.
module ram_copy_engine
  import ram_bus_pkg::*;
#(
  parameter int Bits = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [Bits-1:0]   srcAddr,
  input  logic [Bits-1:0]   dstAddr,
  input  logic [Bits-1:0]   length,
  input  logic [DATA_W-1:0] fillByte,
  output logic              busy,
  output logic              done,
  output logic              chipSelect,
  output logic              writeEnabled,
  output logic [Bits-1:0]   address,
  inout  wire  [DATA_W-1:0] data
);

  localparam logic [Bits-1:0] ONE = {{(Bits-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              state_next;
  logic                mode_q;
  logic                desc_q;
  logic [DATA_W-1:0]   fill_q;
  logic [DATA_W-1:0]   hold;
  logic [Bits-1:0]     remaining;
  logic [Bits-1:0]     src_ptr;
  logic [Bits-1:0]     dst_ptr;
  logic                take;
  logic                overlap;
  logic [Bits-1:0]     diff;
  logic [Bits-1:0]     last_off;
  logic [Bits-1:0]     src_base;
  logic [Bits-1:0]     dst_base;
  logic [DATA_W-1:0]   write_byte;

  // A destination that starts inside the source block must be copied from the top down.
  assign take     = (state == IDLE) && start;
  assign diff     = dstAddr - srcAddr;
  assign overlap  = (mode == MODE_COPY) && (diff != '0) && (diff < length);
  assign last_off = length - ONE;
  assign src_base = overlap ? srcAddr + last_off : srcAddr;
  assign dst_base = overlap ? dstAddr + last_off : dstAddr;

  ram_copy_ptr #(.Bits(Bits)) u_src_ptr (
    .clk        (clk),
    .reset      (reset),
    .load       (take),
    .load_value (src_base),
    .step       (state == WRITE),
    .down       (desc_q),
    .ptr        (src_ptr)
  );

  ram_copy_ptr #(.Bits(Bits)) u_dst_ptr (
    .clk        (clk),
    .reset      (reset),
    .load       (take),
    .load_value (dst_base),
    .step       (state == WRITE),
    .down       (desc_q),
    .ptr        (dst_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_q    <= MODE_COPY;
      desc_q    <= 1'b0;
      fill_q    <= '0;
      hold      <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        mode_q    <= mode;
        desc_q    <= overlap;
        fill_q    <= fillByte;
        remaining <= length;
      end else if (state == WRITE) begin
        remaining <= remaining - ONE;
      end
      if (state == READ) begin
        hold <= data;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0)             state_next = FINISH;
          else if (mode == MODE_FILL)   state_next = WRITE;
          else                          state_next = READ;
        end
      end
      READ:   state_next = WRITE;
      WRITE: begin
        if (remaining == ONE)           state_next = FINISH;
        else if (mode_q == MODE_COPY)   state_next = READ;
        else                            state_next = WRITE;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus signals decode straight from the state register, so the data driver and
  // the write strobe always turn on and off on the same edge.
  assign busy         = (state == READ) || (state == WRITE);
  assign done         = (state == FINISH);
  assign chipSelect   = busy;
  assign writeEnabled = (state == WRITE);
  assign address      = (state == READ)  ? src_ptr :
                        (state == WRITE) ? dst_ptr : '0;
  assign write_byte   = (mode_q == MODE_FILL) ? fill_q : hold;
  assign data         = writeEnabled ? write_byte : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural 64 KiB RAM on the
// tristate bus and hand-computed expected results.
module tb_ram_copy_engine;
  import ram_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = MODE_COPY;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic [7:0]  fill_byte = '0;
  wire         busy;
  wire         done;
  wire         chip_select;
  wire         write_enabled;
  wire  [15:0] address;
  wire  [7:0]  data;

  logic [7:0]  mem [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_val = '0;
  logic        probe = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int cs_cnt = 0;
  int read_cnt = 0;
  int wr_cnt = 0;
  int viol_cnt = 0;
  logic [15:0] wlog [0:255];

  int b0, d0, c0, r0, w0, cyc;

  ram_copy_engine #(.Bits(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .srcAddr      (src_addr),
    .dstAddr      (dst_addr),
    .length       (len),
    .fillByte     (fill_byte),
    .busy         (busy),
    .done         (done),
    .chipSelect   (chip_select),
    .writeEnabled (write_enabled),
    .address      (address),
    .data         (data)
  );

  always #5 clk = ~clk;

  // RAM reads combinationally; the probe value stands in when nobody should drive.
  assign data = (chip_select && !write_enabled) ? mem[address] :
                (probe ? 8'hC3 : 8'hzz);

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_val;
    else if (write_enabled) mem[address] <= data;
  end

  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (chip_select) cs_cnt <= cs_cnt + 1;
    if (chip_select && !write_enabled) read_cnt <= read_cnt + 1;
    if (write_enabled) begin
      wlog[8'(wr_cnt)] <= address;
      wr_cnt <= wr_cnt + 1;
    end
    if ((write_enabled && !chip_select) || (busy != chip_select) || (done && busy))
      viol_cnt <= viol_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pokeMem(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    pre_en = 1'b1;
    pre_addr = a;
    pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic snapshot();
    @(negedge clk);
    #1;
    b0 = busy_cnt; d0 = done_cnt; c0 = cs_cnt; r0 = read_cnt; w0 = wr_cnt;
  endtask

  task automatic applyStimulus(input logic m, input logic [15:0] s, input logic [15:0] d,
                               input logic [15:0] l, input logic [7:0] f);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_byte = f;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the start edge until the done pulse is seen.
  task automatic waitDone(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = done;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic checkQuiet(input string tag);
    probe = 1'b1;
    #1;
    checkOutput(tag, 32'(data), 32'hC3);
    probe = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wn;
    int guard;
    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_cs", 32'(chip_select), 32'd0);
    checkOutput("rst_we", 32'(write_enabled), 32'd0);
    checkOutput("rst_addr", 32'(address), 32'd0);
    checkQuiet("rst_data");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Ascending copy
    pokeMem(16'h0100, 8'h11); pokeMem(16'h0101, 8'h22);
    pokeMem(16'h0102, 8'h33); pokeMem(16'h0103, 8'h44);
    snapshot();
    applyStimulus(MODE_COPY, 16'h0100, 16'h0200, 16'd4, 8'h00);
    waitDone(cyc);
    checkOutput("copy_latency", 32'(cyc), 32'd9);
    @(negedge clk); #1;
    checkOutput("copy_busy", 32'(busy_cnt - b0), 32'd8);
    checkOutput("copy_done", 32'(done_cnt - d0), 32'd1);
    checkOutput("copy_reads", 32'(read_cnt - r0), 32'd4);
    checkOutput("copy_first_wr", 32'(wlog[8'(w0)]), 32'h0200);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("copy_dst%0d", i), 32'(mem[16'h0200 + 16'(i)]), 32'h11 * (i + 1));
    checkOutput("copy_src0", 32'(mem[16'h0100]), 32'h11);
    checkOutput("copy_src3", 32'(mem[16'h0103]), 32'h44);
    checkQuiet("copy_quiet");

    // Overlapping copy runs descending
    for (int i = 0; i < 5; i++) pokeMem(16'h0010 + 16'(i), 8'(i + 1));
    snapshot();
    applyStimulus(MODE_COPY, 16'h0010, 16'h0012, 16'd5, 8'h00);
    waitDone(cyc);
    checkOutput("ovl_latency", 32'(cyc), 32'd11);
    @(negedge clk); #1;
    checkOutput("ovl_first_wr", 32'(wlog[8'(w0)]), 32'h0016);
    checkOutput("ovl_last_wr", 32'(wlog[8'(w0 + 4)]), 32'h0012);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("ovl_dst%0d", i), 32'(mem[16'h0012 + 16'(i)]), 32'(i + 1));
    checkOutput("ovl_src0", 32'(mem[16'h0010]), 32'd1);

    // Fill across the top of the address space
    pokeMem(16'h0002, 8'h5C);
    snapshot();
    applyStimulus(MODE_FILL, 16'h1234, 16'hFFFE, 16'd4, 8'hA5);
    waitDone(cyc);
    checkOutput("fill_latency", 32'(cyc), 32'd5);
    @(negedge clk); #1;
    checkOutput("fill_busy", 32'(busy_cnt - b0), 32'd4);
    checkOutput("fill_cs", 32'(cs_cnt - c0), 32'd4);
    checkOutput("fill_reads", 32'(read_cnt - r0), 32'd0);
    checkOutput("fill_wrap_wr", 32'(wlog[8'(w0 + 2)]), 32'h0000);
    checkOutput("fill_fffe", 32'(mem[16'hFFFE]), 32'hA5);
    checkOutput("fill_ffff", 32'(mem[16'hFFFF]), 32'hA5);
    checkOutput("fill_0000", 32'(mem[16'h0000]), 32'hA5);
    checkOutput("fill_0001", 32'(mem[16'h0001]), 32'hA5);
    checkOutput("fill_0002", 32'(mem[16'h0002]), 32'h5C);

    // Zero length, then a start during the done cycle
    pokeMem(16'h0300, 8'h3C);
    pokeMem(16'h0310, 8'h31);
    snapshot();
    applyStimulus(MODE_COPY, 16'h0100, 16'h0300, 16'd0, 8'h00);
    waitDone(cyc);
    checkOutput("len0_latency", 32'(cyc), 32'd1);
    mode = MODE_COPY; src_addr = 16'h0100; dst_addr = 16'h0310; len = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checkOutput("len0_cs", 32'(cs_cnt - c0), 32'd0);
    checkOutput("len0_done", 32'(done_cnt - d0), 32'd1);
    checkOutput("done_start_busy", 32'(busy), 32'd0);
    checkOutput("len0_dst", 32'(mem[16'h0300]), 32'h3C);
    checkOutput("done_start_dst", 32'(mem[16'h0310]), 32'h31);

    // Second start while busy is dropped
    pokeMem(16'h0400, 8'hB1); pokeMem(16'h0401, 8'hB2); pokeMem(16'h0402, 8'hB3);
    pokeMem(16'h0600, 8'h66);
    snapshot();
    applyStimulus(MODE_COPY, 16'h0400, 16'h0500, 16'd3, 8'h00);
    @(negedge clk);
    @(negedge clk);
    mode = MODE_FILL; src_addr = 16'h0000; dst_addr = 16'h0600; len = 16'd2; fill_byte = 8'hEE;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(cyc);
    checkOutput("busy_start_latency", 32'(cyc), 32'd5);
    @(negedge clk); @(negedge clk); #1;
    checkOutput("busy_start_busy", 32'(busy_cnt - b0), 32'd6);
    checkOutput("busy_start_done", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("busy_start_dst%0d", i), 32'(mem[16'h0500 + 16'(i)]), 32'hB1 + i);
    checkOutput("busy_start_untouched", 32'(mem[16'h0600]), 32'h66);

    // Asynchronous reset in the middle of a WRITE
    for (int i = 0; i < 8; i++) pokeMem(16'h0700 + 16'(i), 8'h71 + 8'(i));
    pokeMem(16'h0802, 8'hEF);
    snapshot();
    applyStimulus(MODE_COPY, 16'h0700, 16'h0800, 16'd8, 8'h00);
    wn = 0;
    guard = 0;
    while (wn < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (write_enabled) wn++;
    end
    checkOutput("rstmid_reached", 32'(wn), 32'd3);
    #1 reset = 1'b0;
    #1;
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_cs", 32'(chip_select), 32'd0);
    checkOutput("rstmid_we", 32'(write_enabled), 32'd0);
    checkOutput("rstmid_addr", 32'(address), 32'd0);
    checkQuiet("rstmid_data");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checkOutput("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("rstmid_kept0", 32'(mem[16'h0800]), 32'h71);
    checkOutput("rstmid_kept1", 32'(mem[16'h0801]), 32'h72);
    checkOutput("rstmid_unwritten", 32'(mem[16'h0802]), 32'hEF);
    pokeMem(16'h0900, 8'h00);
    pokeMem(16'h0901, 8'h00);
    snapshot();
    applyStimulus(MODE_COPY, 16'h0700, 16'h0900, 16'd2, 8'h00);
    waitDone(cyc);
    checkOutput("restart_latency", 32'(cyc), 32'd5);
    @(negedge clk); #1;
    checkOutput("restart_dst0", 32'(mem[16'h0900]), 32'h71);
    checkOutput("restart_dst1", 32'(mem[16'h0901]), 32'h72);

    checkOutput("protocol_violations", 32'(viol_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
